// File: rtl/noise_pkg.sv
// Shared constants for the noise channel: period tables per region,
// the long-mode feedback tap and the LFSR seed.
package noise_pkg;

    localparam int unsigned TABLE_W   = 12;
    localparam int unsigned LONG_TAP  = 1;
    localparam int unsigned LFSR_SEED = 1;

    typedef enum logic {
        REGION_NTSC = 1'b0,
        REGION_PAL  = 1'b1
    } region_e;

    function automatic logic [TABLE_W-1:0] ntsc_period(input logic [3:0] idx);
        logic [TABLE_W-1:0] p;
        case (idx)
            4'd0:    p = 12'd4;
            4'd1:    p = 12'd8;
            4'd2:    p = 12'd16;
            4'd3:    p = 12'd32;
            4'd4:    p = 12'd64;
            4'd5:    p = 12'd96;
            4'd6:    p = 12'd128;
            4'd7:    p = 12'd160;
            4'd8:    p = 12'd202;
            4'd9:    p = 12'd254;
            4'd10:   p = 12'd380;
            4'd11:   p = 12'd508;
            4'd12:   p = 12'd762;
            4'd13:   p = 12'd1016;
            4'd14:   p = 12'd2034;
            4'd15:   p = 12'd4068;
            default: p = 12'd4;
        endcase
        return p;
    endfunction

    function automatic logic [TABLE_W-1:0] pal_period(input logic [3:0] idx);
        logic [TABLE_W-1:0] p;
        case (idx)
            4'd0:    p = 12'd4;
            4'd1:    p = 12'd8;
            4'd2:    p = 12'd14;
            4'd3:    p = 12'd30;
            4'd4:    p = 12'd60;
            4'd5:    p = 12'd88;
            4'd6:    p = 12'd118;
            4'd7:    p = 12'd148;
            4'd8:    p = 12'd188;
            4'd9:    p = 12'd236;
            4'd10:   p = 12'd354;
            4'd11:   p = 12'd472;
            4'd12:   p = 12'd708;
            4'd13:   p = 12'd944;
            4'd14:   p = 12'd1890;
            4'd15:   p = 12'd3778;
            default: p = 12'd4;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/noise_period_rom.sv
// Combinational period lookup: 4-bit index to timer period for the
// region selected at elaboration.
import noise_pkg::*;

module noise_period_rom #(
    parameter int PERIOD_W = 12,
    parameter int REGION   = 0
) (
    input  logic [3:0]          NF,
    output logic [PERIOD_W-1:0] NNF
);

    logic [TABLE_W-1:0] table_s;

    // Region table select and zero-extension to the timer width
    always_comb begin
        table_s = 12'd0;
        if (REGION == int'(REGION_PAL)) begin
            table_s = pal_period(NF);
        end else begin
            table_s = ntsc_period(NF);
        end
        NNF = PERIOD_W'(table_s);
    end

endmodule

// File: rtl/noise_period_lfsr.sv
// Noise channel core: latched period/mode, STEP-enabled reload timer and
// the noise LFSR clocked by each reload.
import noise_pkg::*;

module noise_period_lfsr #(
    parameter int PERIOD_W  = 12,
    parameter int LFSR_W    = 15,
    parameter int SHORT_TAP = 6,
    parameter int REGION    = 0
) (
    input  logic                CLK,
    input  logic                n_RES,
    input  logic                WR,
    input  logic [3:0]          NF,
    input  logic                MODE,
    input  logic                STEP,
    output logic [PERIOD_W-1:0] NNF,
    output logic                TICK,
    output logic                RND
);

    if (PERIOD_W < 12) begin : g_bad_period_w
        $error("noise_period_lfsr: PERIOD_W must be at least 12");
    end
    if (SHORT_TAP >= LFSR_W) begin : g_bad_short_tap
        $error("noise_period_lfsr: SHORT_TAP must be below LFSR_W");
    end

    localparam logic [PERIOD_W-1:0] TIMER_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] TIMER_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};

    logic [3:0]          nf_r;
    logic                mode_r;
    logic [PERIOD_W-1:0] timer_r;
    logic [LFSR_W-1:0]   lfsr_r;
    logic                tick_r;

    logic [PERIOD_W-1:0] nnf_s;
    logic                reload_s;
    logic                fb_s;
    logic [PERIOD_W-1:0] timer_nxt_s;
    logic [LFSR_W-1:0]   lfsr_nxt_s;

    noise_period_rom #(
        .PERIOD_W (PERIOD_W),
        .REGION   (REGION)
    ) u_rom (
        .NF  (nf_r),
        .NNF (nnf_s)
    );

    // Reload decision, feedback selection and next-state for timer/LFSR.
    // The reload uses the currently latched index and mode, so a WR in the
    // same cycle only affects the following period.
    always_comb begin
        reload_s    = STEP && (timer_r == TIMER_ZERO);
        fb_s        = 1'b0;
        timer_nxt_s = timer_r;
        lfsr_nxt_s  = lfsr_r;
        if (mode_r) begin
            fb_s = lfsr_r[0] ^ lfsr_r[SHORT_TAP];
        end else begin
            fb_s = lfsr_r[0] ^ lfsr_r[LONG_TAP];
        end
        if (reload_s) begin
            timer_nxt_s = nnf_s - TIMER_ONE;
            lfsr_nxt_s  = {fb_s, lfsr_r[LFSR_W-1:1]};
        end else if (STEP) begin
            timer_nxt_s = timer_r - TIMER_ONE;
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // Control latches written by the host strobe
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            nf_r   <= 4'd0;
            mode_r <= 1'b0;
        end else if (WR) begin
            nf_r   <= NF;
            mode_r <= MODE;
        end else begin
            nf_r   <= nf_r;
            mode_r <= mode_r;
        end
    end

    // Timer, LFSR and reload pulse
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            timer_r <= TIMER_ZERO;
            lfsr_r  <= LFSR_W'(LFSR_SEED);
            tick_r  <= 1'b0;
        end else begin
            timer_r <= timer_nxt_s;
            lfsr_r  <= lfsr_nxt_s;
            tick_r  <= reload_s;
        end
    end

    assign NNF  = nnf_s;
    assign TICK = tick_r;
    assign RND  = ~lfsr_r[0];

endmodule

// File: tb/tb_noise_period_lfsr.sv
// Scoreboard bench for noise_period_lfsr: a cycle model pushes expected
// TICK/RND/NNF per clock, each scenario task pops and compares.
module tb_noise_period_lfsr;

    logic        CLK = 1'b0;
    logic        n_RES = 1'b0;
    logic        WR = 1'b0;
    logic [3:0]  NF = 4'd0;
    logic        MODE = 1'b0;
    logic        STEP = 1'b0;
    logic [11:0] NNF;
    logic        TICK;
    logic        RND;
    logic [11:0] NNF_PAL;
    logic        TICK_PAL;
    logic        RND_PAL;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        tick;
        logic        rnd;
        logic [11:0] nnf;
    } exp_t;

    exp_t sb[$];

    int ntsc_tab[16] = '{4, 8, 16, 32, 64, 96, 128, 160, 202, 254, 380, 508, 762, 1016, 2034, 4068};
    int pal_tab[16]  = '{4, 8, 14, 30, 60, 88, 118, 148, 188, 236, 354, 472, 708, 944, 1890, 3778};

    logic [3:0]  m_nf;
    logic        m_mode;
    logic [11:0] m_timer;
    logic [14:0] m_lfsr;

    noise_period_lfsr #(.PERIOD_W(12), .LFSR_W(15), .SHORT_TAP(6), .REGION(0)) dut (
        .CLK(CLK), .n_RES(n_RES), .WR(WR), .NF(NF), .MODE(MODE), .STEP(STEP),
        .NNF(NNF), .TICK(TICK), .RND(RND)
    );

    noise_period_lfsr #(.PERIOD_W(12), .LFSR_W(15), .SHORT_TAP(6), .REGION(1)) dut_pal (
        .CLK(CLK), .n_RES(n_RES), .WR(WR), .NF(NF), .MODE(MODE), .STEP(STEP),
        .NNF(NNF_PAL), .TICK(TICK_PAL), .RND(RND_PAL)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_nf    = 4'd0;
        m_mode  = 1'b0;
        m_timer = 12'd0;
        m_lfsr  = 15'd1;
        sb.delete();
    endtask

    task automatic do_reset();
        n_RES = 1'b0;
        WR = 1'b0; STEP = 1'b0; NF = 4'd0; MODE = 1'b0;
        @(posedge CLK); #1;
        n_RES = 1'b1;
        model_reset();
    endtask

    // Drive one clock of stimulus, advance the model, queue the expectation.
    task automatic cycle(input logic s, input logic w, input logic [3:0] n, input logic m);
        logic fb;
        logic t;
        STEP = s; WR = w; NF = n; MODE = m;
        t = s && (m_timer == 12'd0);
        if (t) begin
            m_timer = 12'(ntsc_tab[int'(m_nf)] - 1);
            fb = m_lfsr[0] ^ (m_mode ? m_lfsr[6] : m_lfsr[1]);
            m_lfsr = {fb, m_lfsr[14:1]};
        end else if (s) begin
            m_timer = m_timer - 12'd1;
        end
        if (w) begin
            m_nf = n;
            m_mode = m;
        end
        sb.push_back({t, ~m_lfsr[0], 12'(ntsc_tab[int'(m_nf)])});
        @(posedge CLK); #1;
        WR = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        n_RES = 1'b0;
        #2;
        checks++;
        if ({NNF, TICK, RND} !== {12'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: NNF=%0d TICK=%b RND=%b, want NNF=4 TICK=0 RND=0", NNF, TICK, RND);
        end
        @(posedge CLK); #1;
        n_RES = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (TICK !== 1'b1 || {TICK, RND, NNF} !== {e.tick, e.rnd, e.nnf}) begin
            errors++;
            $display("FAIL reset_first_step: TICK=%b RND=%b NNF=%0d, want TICK=1 RND=%b NNF=%0d",
                     TICK, RND, NNF, e.rnd, e.nnf);
        end
    endtask

    task automatic test_table_sweep();
        exp_t e;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 4'(i), 1'b0);
            e = sb.pop_front();
            checks++;
            if ({TICK, RND, NNF} !== {e.tick, e.rnd, e.nnf}) begin
                errors++;
                $display("FAIL table_ntsc[%0d]: NNF=%0d TICK=%b RND=%b, want NNF=%0d TICK=%b RND=%b",
                         i, NNF, TICK, RND, e.nnf, e.tick, e.rnd);
            end
            checks++;
            if ({TICK_PAL, RND_PAL, NNF_PAL} !== {e.tick, e.rnd, 12'(pal_tab[i])}) begin
                errors++;
                $display("FAIL table_pal[%0d]: NNF=%0d TICK=%b RND=%b, want NNF=%0d TICK=%b RND=%b",
                         i, NNF_PAL, TICK_PAL, RND_PAL, pal_tab[i], e.tick, e.rnd);
            end
        end
    endtask

    task automatic test_period();
        exp_t e;
        int last;
        int gaps;
        int want;
        logic s;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            cycle(1'b0, 1'b1, 4'd3, 1'b0);
            void'(sb.pop_front());
            want = (pass == 0) ? 32 : 96;
            last = -1;
            gaps = 0;
            for (int i = 0; i < 400 && gaps < 3; i++) begin
                s = (pass == 0) ? 1'b1 : ((i % 3) == 0);
                cycle(s, 1'b0, 4'd0, 1'b0);
                e = sb.pop_front();
                checks++;
                if ({TICK, RND, NNF} !== {e.tick, e.rnd, e.nnf}) begin
                    errors++;
                    $display("FAIL period_cycle[%0d]: TICK=%b RND=%b NNF=%0d, want %b %b %0d",
                             i, TICK, RND, NNF, e.tick, e.rnd, e.nnf);
                end
                if (TICK === 1'b1) begin
                    if (last >= 0) begin
                        gaps++;
                        checks++;
                        if (i - last != want) begin
                            errors++;
                            $display("FAIL period_gap: got %0d cycles, want %0d", i - last, want);
                        end
                    end
                    last = i;
                end
            end
            checks++;
            if (gaps < 3) begin
                errors++;
                $display("FAIL period_timeout: saw %0d gaps, want 3", gaps);
            end
        end
    endtask

    task automatic test_sequence();
        exp_t e;
        int ticks;
        int returns;
        // Short mode: seed 1 must come back after 93 reloads
        do_reset();
        cycle(1'b0, 1'b1, 4'd0, 1'b1);
        void'(sb.pop_front());
        ticks = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, 1'b0, 4'd0, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({TICK, RND} !== {e.tick, e.rnd}) begin
                errors++;
                $display("FAIL short_seq[%0d]: TICK=%b RND=%b, want %b %b", i, TICK, RND, e.tick, e.rnd);
            end
            if (TICK === 1'b1) begin
                ticks++;
                if (dut.lfsr_r == 15'd1) break;
            end
        end
        checks++;
        if (ticks != 93) begin
            errors++;
            $display("FAIL short_length: got %0d ticks, want 93", ticks);
        end
        // Long mode: a long window must track the model and never revisit the seed
        do_reset();
        ticks = 0;
        returns = 0;
        for (int i = 0; i < 9000 && ticks < 2000; i++) begin
            cycle(1'b1, 1'b0, 4'd0, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({TICK, RND} !== {e.tick, e.rnd}) begin
                errors++;
                $display("FAIL long_seq[%0d]: TICK=%b RND=%b, want %b %b", i, TICK, RND, e.tick, e.rnd);
            end
            if (TICK === 1'b1) begin
                ticks++;
                if (dut.lfsr_r == 15'd1) returns++;
            end
        end
        checks++;
        if (returns != 0 || dut.lfsr_r !== m_lfsr) begin
            errors++;
            $display("FAIL long_state: lfsr=%h returns=%0d, want lfsr=%h returns=0", dut.lfsr_r, returns, m_lfsr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int tick_at[3];
        int nt;
        int seen;
        logic w;
        do_reset();
        nt = 0;
        seen = 0;
        for (int i = 0; i < 5000 && nt < 3; i++) begin
            // write NF=15 on the second reload under NF=0
            w = (m_timer == 12'd0) && (seen == 1) && (nt == 0);
            cycle(1'b1, w, 4'd15, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({TICK, RND, NNF} !== {e.tick, e.rnd, e.nnf}) begin
                errors++;
                $display("FAIL coincide_cycle[%0d]: TICK=%b RND=%b NNF=%0d, want %b %b %0d",
                         i, TICK, RND, NNF, e.tick, e.rnd, e.nnf);
            end
            if (TICK === 1'b1) begin
                if (seen == 0) seen = 1;
                else if (nt < 3) begin
                    tick_at[nt] = i;
                    nt++;
                end
            end
        end
        checks++;
        if (nt < 3) begin
            errors++;
            $display("FAIL coincide_timeout: saw %0d ticks, want 3", nt);
        end else begin
            checks++;
            if (tick_at[1] - tick_at[0] != 4) begin
                errors++;
                $display("FAIL coincide_old_period: got %0d, want 4", tick_at[1] - tick_at[0]);
            end
            checks++;
            if (tick_at[2] - tick_at[1] != 4068) begin
                errors++;
                $display("FAIL coincide_new_period: got %0d, want 4068", tick_at[2] - tick_at[1]);
            end
        end
    endtask

    task automatic test_reset_midcount();
        exp_t e;
        int guard;
        do_reset();
        cycle(1'b0, 1'b1, 4'd15, 1'b0);
        void'(sb.pop_front());
        guard = 0;
        while (dut.timer_r != 12'd1000 && guard < 6000) begin
            cycle(1'b1, 1'b0, 4'd0, 1'b0);
            void'(sb.pop_front());
            guard++;
        end
        checks++;
        if (guard >= 6000) begin
            errors++;
            $display("FAIL midcount_timeout: timer=%0d, want 1000", dut.timer_r);
        end
        STEP = 1'b0;
        #2;
        n_RES = 1'b0;
        #1;
        checks++;
        if ({dut.timer_r, dut.lfsr_r, TICK, NNF} !== {12'd0, 15'd1, 1'b0, 12'd4}) begin
            errors++;
            $display("FAIL midcount_async: timer=%0d lfsr=%h TICK=%b NNF=%0d, want 0 0001 0 4",
                     dut.timer_r, dut.lfsr_r, TICK, NNF);
        end
        @(posedge CLK); #1;
        n_RES = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (TICK !== 1'b1 || {TICK, RND, NNF} !== {e.tick, e.rnd, e.nnf}) begin
            errors++;
            $display("FAIL midcount_release: TICK=%b RND=%b NNF=%0d, want 1 %b %0d", TICK, RND, NNF, e.rnd, e.nnf);
        end
    endtask

    initial begin
        model_reset();
        @(posedge CLK); #1;
        test_reset();
        test_table_sweep();
        test_period();
        test_sequence();
        test_back_to_back();
        test_reset_midcount();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
